// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive framer.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Clocks per serial bit, truncated.
    function automatic int calc_cpb(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect on the
// synchronized value. All flops reset to 1 so an idle line never looks like
// a start bit right after reset.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rxs,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    // Next values: plain shift of the line through the three stages.
    always_comb begin
        s1_d   = rx;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign rxs  = s2_q;
    assign fall = prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: 8 data bits LSB first, optional parity, one stop bit.
// Bits are decided by majority of three samples around the bit centre.
//
//   state  | meaning
//   IDLE   | line idle, waiting for falling edge
//   START  | timing start bit, rejects glitches
//   DATA   | shifting in 8 data bits
//   PARITY | checking parity bit
//   STOP   | checking stop bit, queues result pulse
//   BREAK  | stop bit was low, wait for line high
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int clk_freq    = 1000000,
    parameter int baud_rate   = 9600,
    parameter int parity_mode = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] doutrx,
    output logic       donerx,
    output logic       ferr,
    output logic       perr,
    output logic       busy
);

    localparam int CPB  = calc_cpb(clk_freq, baud_rate);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);
    localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] C_S1   = CW'(HALF);
    localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic          ODD_L  = (parity_mode == PAR_ODD);
    localparam logic          PAR_EN = (parity_mode != PAR_NONE);

    logic rxs, fall;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bitn_q, bitn_d;
    logic [1:0] samp_q, samp_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] dout_q, dout_d;
    logic par_bad_q, par_bad_d;
    logic done_pend_q, done_pend_d;
    logic ferr_pend_q, ferr_pend_d;
    logic perr_pend_q, perr_pend_d;
    logic donerx_q, donerx_d;
    logic ferr_q, ferr_d;
    logic perr_q, perr_d;
    logic dec, bit_val;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rxs  (rxs),
        .fall (fall)
    );

    // Bit decision strobe and majority vote over the three centre samples.
    always_comb begin
        dec = (cnt_q == C_DEC) &&
              (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});
        bit_val = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs) | (samp_q[0] & rxs);
    end

    // Next-state logic; any return to IDLE that coincides with a falling
    // edge goes straight to START so back-to-back frames are not missed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (fall) state_d = ST_START;
            ST_START:  if (dec) state_d = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:   if (dec && bitn_q == 3'd7) state_d = PAR_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (dec) state_d = ST_STOP;
            ST_STOP:   if (dec) state_d = bit_val ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rxs) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE && fall) state_d = ST_START;
    end

    // Datapath: free-running bit timer while framing, sampling, shifting,
    // parity latch and a one-cycle pending stage ahead of the output pulses.
    always_comb begin
        cnt_d       = '0;
        samp_d      = samp_q;
        bitn_d      = bitn_q;
        sh_d        = sh_q;
        par_bad_d   = par_bad_q;
        done_pend_d = 1'b0;
        ferr_pend_d = 1'b0;
        perr_pend_d = 1'b0;
        donerx_d    = done_pend_q;
        ferr_d      = ferr_pend_q;
        perr_d      = perr_pend_q;
        dout_d      = done_pend_q ? sh_q : dout_q;

        if (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + C_ONE;
        if (cnt_q == C_S0) samp_d[1] = rxs;
        if (cnt_q == C_S1) samp_d[0] = rxs;

        if (dec) begin
            case (state_q)
                ST_DATA: begin
                    sh_d   = {bit_val, sh_q[7:1]};
                    bitn_d = bitn_q + 3'd1;
                end
                ST_PARITY: par_bad_d = (^sh_q) ^ bit_val ^ ODD_L;
                ST_STOP: begin
                    if (!bit_val)       ferr_pend_d = 1'b1;
                    else if (par_bad_q) perr_pend_d = 1'b1;
                    else                done_pend_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (state_d == ST_START && state_q != ST_START) begin
            cnt_d     = '0;
            bitn_d    = '0;
            par_bad_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            samp_q      <= '0;
            bitn_q      <= '0;
            sh_q        <= '0;
            dout_q      <= '0;
            par_bad_q   <= 1'b0;
            done_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            perr_pend_q <= 1'b0;
            donerx_q    <= 1'b0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            samp_q      <= samp_d;
            bitn_q      <= bitn_d;
            sh_q        <= sh_d;
            dout_q      <= dout_d;
            par_bad_q   <= par_bad_d;
            done_pend_q <= done_pend_d;
            ferr_pend_q <= ferr_pend_d;
            perr_pend_q <= perr_pend_d;
            donerx_q    <= donerx_d;
            ferr_q      <= ferr_d;
            perr_q      <= perr_d;
        end
    end

    // Outputs.
    always_comb begin
        busy   = (state_q != ST_IDLE);
        doutrx = dout_q;
        donerx = donerx_q;
        ferr   = ferr_q;
        perr   = perr_q;
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: one instance without parity, one with even parity.
// Stimulus pushes the expected outcome of each frame; monitors pop on pulses.
module tb_uart_rx_framer;

    localparam int CPB  = 104;
    localparam int HALF = 52;

    typedef struct {
        int         kind;   // 0 = byte, 1 = framing error, 2 = parity error
        logic [7:0] data;
        longint     t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst0, rst1, rx0, rx1;
    logic [7:0] dout0, dout1;
    logic done0, ferr0, perr0, busy0;
    logic done1, ferr1, perr1, busy1;

    exp_t q0[$];
    exp_t q1[$];
    int n_checks = 0;
    int n_fail = 0;
    longint cyc = 0;
    logic [7:0] last0 = 8'h00;
    logic [7:0] last1 = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    uart_rx_framer dut0 (
        .clk(clk), .rst(rst0), .rx(rx0), .doutrx(dout0),
        .donerx(done0), .ferr(ferr0), .perr(perr0), .busy(busy0)
    );

    uart_rx_framer #(.clk_freq(1000000), .baud_rate(9600), .parity_mode(1)) dut1 (
        .clk(clk), .rst(rst1), .rx(rx1), .doutrx(dout1),
        .donerx(done1), .ferr(ferr1), .perr(perr1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Result of a whole frame from its bits: stop low is a framing error,
    // then parity, then a good byte. The result appears a fixed time after
    // the start bit: 2-flop sync, 1 cycle edge detect, HALF+1 to the start
    // decision, one bit period per further bit, 2 cycles of output pipeline.
    task automatic check_evt(input int which, input logic d, input logic f,
                             input logic p, input logic [7:0] dout);
        exp_t e;
        int kind;
        int nb;
        chk($sformatf("onehot_dut%0d", which), 32'(d) + 32'(f) + 32'(p), 32'd1);
        kind = d ? 0 : (f ? 1 : 2);
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse_dut%0d: actual kind=%0d required no pulse", which, kind);
            return;
        end
        if (which == 0) e = q0.pop_front();
        else            e = q1.pop_front();
        nb = (which == 1) ? 11 : 10;
        chk($sformatf("kind_dut%0d", which), 32'(kind), 32'(e.kind));
        chk($sformatf("latency_dut%0d", which), 32'(cyc - e.t0), 32'(6 + HALF + (nb - 1) * CPB));
        if (kind == 0) begin
            chk($sformatf("doutrx_dut%0d", which), 32'(dout), 32'(e.data));
            if (which == 0) last0 = e.data;
            else            last1 = e.data;
        end else begin
            chk($sformatf("doutrx_hold_dut%0d", which), 32'(dout),
                32'((which == 0) ? last0 : last1));
        end
    endtask

    // Monitors: compare on every presented pulse.
    always @(negedge clk) if (rst0 && (done0 || ferr0 || perr0)) check_evt(0, done0, ferr0, perr0, dout0);
    always @(negedge clk) if (rst1 && (done1 || ferr1 || perr1)) check_evt(1, done1, ferr1, perr1, dout1);

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    // Drives one frame starting at the current falling clock edge.
    task automatic send(input int which, input logic [7:0] d, input logic par_bit,
                        input logic stop_bit);
        exp_t e;
        e.data = d;
        e.t0   = cyc;
        if (!stop_bit)                           e.kind = 1;
        else if (which == 1 && ((^d) ^ par_bit)) e.kind = 2;
        else                                     e.kind = 0;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
        set_rx(which, 1'b0);
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, d[i]);
            hold(CPB);
        end
        if (which == 1) begin
            set_rx(which, par_bit);
            hold(CPB);
        end
        set_rx(which, stop_bit);
        hold(CPB);
    endtask

    initial begin
        logic [7:0] v55;
        logic [7:0] d;
        logic       stop;
        rst0 = 1'b0;
        rst1 = 1'b0;
        rx0  = 1'b1;
        rx1  = 1'b1;
        hold(5);
        chk("rst_dout0", 32'(dout0), 32'h0);
        chk("rst_pulses0", {29'd0, done0, ferr0, perr0}, 32'h0);
        chk("rst_busy0", 32'(busy0), 32'h0);
        chk("rst_dout1", 32'(dout1), 32'h0);
        chk("rst_pulses1", {29'd0, done1, ferr1, perr1}, 32'h0);
        chk("rst_busy1", 32'(busy1), 32'h0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        hold(20);

        send(0, 8'hA5, 1'b0, 1'b1);
        hold(20);

        // Short low glitch must be rejected.
        rx0 = 1'b0;
        hold(15);
        chk("glitch_busy", 32'(busy0), 32'h1);
        hold(5);
        rx0 = 1'b1;
        hold(100);
        chk("glitch_idle", 32'(busy0), 32'h0);

        // Stop bit low followed by a long break.
        send(0, 8'h3C, 1'b0, 1'b0);
        hold(300);
        chk("break_busy", 32'(busy0), 32'h1);
        hold(200);
        rx0 = 1'b1;
        hold(5);
        chk("break_exit", 32'(busy0), 32'h0);
        hold(20);

        // Even parity: 8'h07 has odd weight, so parity bit 1 is correct.
        send(1, 8'h07, 1'b1, 1'b1);
        hold(20);
        send(1, 8'h07, 1'b0, 1'b1);
        hold(20);

        // Back-to-back frames.
        send(0, 8'h00, 1'b0, 1'b1);
        send(0, 8'hFF, 1'b0, 1'b1);
        hold(20);

        // Reset in the middle of data bit 4.
        v55 = 8'h55;
        rx0 = 1'b0;
        hold(CPB);
        for (int i = 0; i < 4; i++) begin
            rx0 = v55[i];
            hold(CPB);
        end
        rx0 = v55[4];
        hold(50);
        rst0 = 1'b0;
        rx0  = 1'b1;
        hold(10);
        chk("midrst_busy", 32'(busy0), 32'h0);
        chk("midrst_dout", 32'(dout0), 32'h0);
        rst0  = 1'b1;
        last0 = 8'h00;
        hold(50);
        send(0, 8'h81, 1'b0, 1'b1);
        hold(20);

        // Random frames, occasional framing errors.
        for (int n = 0; n < 10; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send(0, d, 1'b0, stop);
            if (!stop) begin
                hold($urandom_range(10, 100));
                rx0 = 1'b1;
            end
            hold($urandom_range(0, 30));
        end
        for (int n = 0; n < 8; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send(1, d, 1'($urandom_range(0, 1)), stop);
            if (!stop) begin
                hold($urandom_range(10, 100));
                rx1 = 1'b1;
            end
            hold($urandom_range(0, 30));
        end

        for (int i = 0; i < 3000 && (q0.size() != 0 || q1.size() != 0); i++) hold(1);
        chk("drain_q0", 32'(q0.size()), 32'h0);
        chk("drain_q1", 32'(q1.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 Parameter clk_freq, default 1000000, system clock frequency in Hz.
REQ-002 Parameter baud_rate, default 9600, serial bit rate in bit/s.
REQ-003 Parameter parity_mode, default 0, selects parity: 0 = none, 1 = even, 2 = odd.
REQ-004 Port clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-low.
REQ-006 Port rx  input  1  asynchronous serial line, idle high.
REQ-007 Port doutrx  output  8  last correctly framed data byte.
REQ-008 Port donerx  output  1  single-cycle pulse, new valid byte on doutrx.
REQ-009 Port ferr  output  1  single-cycle pulse, framing error (stop bit sampled low).
REQ-010 Port perr  output  1  single-cycle pulse, parity mismatch; held 0 when parity_mode = 0.
REQ-011 Port busy  output  1  high in every state except IDLE.

Function
REQ-012 CPB = clk_freq / baud_rate, integer truncation (default 104); HALF = CPB / 2 (default 52).
REQ-013 rx shall pass through a 2-flop synchronizer before use; all timing is relative to the synchronized signal rxs.
REQ-014 Bit value = majority of three rxs samples at bit-counter values HALF-1, HALF and HALF+1; decision taken at HALF+1.
REQ-015 States: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-016 IDLE: a high-to-low transition of rxs shall enter START with the bit counter cleared to 0.
REQ-017 START: the bit decision 0 shall enter DATA; the decision 1 shall return to IDLE with no output pulse (glitch rejection).
REQ-018 Each subsequent bit shall be decided exactly CPB clocks after the previous decision.
REQ-019 DATA: 8 bits, LSB first, shifted into an internal register; after bit 7, go to PARITY if parity_mode != 0, else STOP.
REQ-020 PARITY: even mode expects XOR(data, parity bit) = 0; odd mode expects 1; the result is latched for STOP.
REQ-021 STOP: decision 1 with parity OK shall load doutrx and pulse donerx in the next cycle, then go to IDLE.
REQ-022 STOP: decision 1 with parity bad shall pulse perr, leave doutrx unchanged and not pulse donerx, then go to IDLE.
REQ-023 STOP: decision 0 shall pulse ferr, leave doutrx unchanged, and enter BREAK; perr shall not be pulsed.
REQ-024 BREAK: wait until rxs = 1, then go to IDLE; no new start bit shall be recognized while in BREAK.
REQ-025 A falling edge on rxs in the same cycle as the return to IDLE shall be recognized as a start bit.
REQ-026 At most one of donerx, ferr and perr shall be high in any cycle.
REQ-027 Latency: donerx shall rise 2 clocks after the stop-bit decision cycle, on top of the 2-cycle synchronizer delay.

Reset
REQ-028 While rst is low: state = IDLE, counters = 0, shift register = 0, doutrx = 8'h00, donerx/ferr/perr/busy = 0, synchronizer flops = 1.
REQ-029 Reset asserted mid-frame shall abort the frame with no output pulse; after release, the first frame received after the line is seen idle high shall decode normally.

Structure
REQ-030 Package uart_pkg shall hold the state enum, the parity_mode encodings, and a function computing CPB from clk_freq and baud_rate.
REQ-031 One sub-module, uart_rx_sync, shall contain the 2-flop synchronizer and the falling-edge detector.

Verification
REQ-032 Defaults, line drives 8'hA5 (frame 0,1,0,1,0,0,1,0,1,1) at 104 clk/bit -> one donerx pulse, doutrx = 8'hA5, ferr = perr = 0.
REQ-033 Low glitch on rx of 20 clocks in IDLE -> returns to IDLE, busy drops, no donerx/ferr/perr pulse.
REQ-034 Byte 8'h3C with stop bit forced 0, then line held low 500 clocks -> one ferr pulse, doutrx keeps its old value, busy stays high until rx returns high.
REQ-035 parity_mode = 1, byte 8'h07 with parity 1 -> donerx, doutrx = 8'h07; same byte with parity 0 -> perr pulse, no donerx.
REQ-036 Back-to-back frames 8'h00 and 8'hFF with no idle gap -> two donerx pulses carrying 8'h00 and then 8'hFF.
REQ-037 Reset asserted during data bit 4 of 8'h55, then frame 8'h81 sent -> no pulse for the aborted frame, donerx with doutrx = 8'h81.
